// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, presents it to instruction memory,
// and captures the returned word (or a fetch fault) into the IF/ID register.
//
// Handshake semantics: there is no valid/ready pair on this stage. stall is
// the downstream "not ready" signal (hold everything); flush and redirect_en
// kill the slot being written. id_valid marks a live slot. Per-edge priority
// is rst > redirect_en > flush > stall > normal fetch.
//
// Only one fetch fault may be in flight. After emitting a faulted slot the
// stage parks in FAULT_WAIT with the PC frozen, emitting bubbles until a
// redirect (trap vector) arrives.
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [63:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        id_exc_en,
  output logic [3:0]  id_exc_code,
  output logic [63:0] id_exc_val,
  output logic        fault_wait
);

  typedef enum logic {
    RUN        = 1'b0,
    FAULT_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pc_plus4;

  logic        id_valid_d;
  logic [63:0] id_pc_d;
  logic [63:0] id_pc_plus4_d;
  logic [31:0] id_instr_d;
  logic        id_exc_en_d;
  logic [3:0]  id_exc_code_d;
  logic [63:0] id_exc_val_d;

  logic        misaligned;
  logic        fault;
  logic [3:0]  fault_code;
  logic [63:0] fault_val;

  assign imem_addr  = pc_q;
  assign fault_wait = (state_q == FAULT_WAIT);
  assign pc_plus4   = pc_q + 64'd4;

  // Fetch fault detection on the current PC; misalignment outranks imem faults.
  always_comb begin
    misaligned = (pc_q[1:0] != 2'b00);
    fault      = misaligned | imem_exc_en;
    fault_code = 4'd0;
    fault_val  = 64'd0;
    if (misaligned) begin
      fault_code = 4'd0;
      fault_val  = pc_q;
    end else if (imem_exc_en) begin
      fault_code = imem_exc_code;
      fault_val  = imem_exc_val;
    end
  end

  // Next-state and next IF/ID contents; defaults hold every register.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid;
    id_pc_d       = id_pc;
    id_pc_plus4_d = id_pc_plus4;
    id_instr_d    = id_instr;
    id_exc_en_d   = id_exc_en;
    id_exc_code_d = id_exc_code;
    id_exc_val_d  = id_exc_val;

    if (redirect_en) begin
      // Target is taken unchecked; a misaligned target faults on the next fetch.
      pc_d        = redirect_pc;
      state_d     = RUN;
      id_valid_d  = 1'b0;
      id_instr_d  = NOP_INSTR;
      id_exc_en_d = 1'b0;
    end else if (flush) begin
      id_valid_d  = 1'b0;
      id_instr_d  = NOP_INSTR;
      id_exc_en_d = 1'b0;
    end else if (stall) begin
      // Hold everything, including a pending fault slot in FAULT_WAIT.
    end else begin
      case (state_q)
        RUN: begin
          id_valid_d    = 1'b1;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          if (fault) begin
            id_instr_d    = NOP_INSTR;
            id_exc_en_d   = 1'b1;
            id_exc_code_d = fault_code;
            id_exc_val_d  = fault_val;
            state_d       = FAULT_WAIT;
          end else begin
            id_instr_d    = imem_instr;
            id_exc_en_d   = 1'b0;
            id_exc_code_d = 4'd0;
            id_exc_val_d  = 64'd0;
            pc_d          = pc_plus4;
          end
        end
        FAULT_WAIT: begin
          // Fault slot has been consumed; emit bubbles until redirected.
          id_valid_d  = 1'b0;
          id_instr_d  = NOP_INSTR;
          id_exc_en_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // PC, state and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 64'd0;
      id_pc_plus4 <= 64'd4;
      id_instr    <= NOP_INSTR;
      id_exc_en   <= 1'b0;
      id_exc_code <= 4'd0;
      id_exc_val  <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_valid    <= id_valid_d;
      id_pc       <= id_pc_d;
      id_pc_plus4 <= id_pc_plus4_d;
      id_instr    <= id_instr_d;
      id_exc_en   <= id_exc_en_d;
      id_exc_code <= id_exc_code_d;
      id_exc_val  <= id_exc_val_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table covering reset, sequential
// fetch, stall, flush, redirect, fetch faults and PC wrap, followed by
// hand-written reset-in-FAULT_WAIT and back-to-back throughput sequences.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        id_valid;
  logic [63:0] id_pc, id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_exc_en;
  logic [3:0]  id_exc_code;
  logic [63:0] id_exc_val;
  logic        fault_wait;

  int n_checks = 0;
  int n_fail   = 0;

  logic [95:0] exp_q[$];

  typedef struct {
    logic        rst, stall, flush, redir;
    logic [63:0] rpc;
    logic [31:0] instr;
    logic        xen;
    logic [3:0]  xcode;
    logic [63:0] xval;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc, e_p4;
    logic [31:0] e_instr;
    logic        e_xen;
    logic [3:0]  e_code;
    logic [63:0] e_val;
    logic        e_fw;
  } vec_t;

  vec_t vt[24];

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code),
    .imem_exc_val(imem_exc_val),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_instr(id_instr), .id_exc_en(id_exc_en), .id_exc_code(id_exc_code),
    .id_exc_val(id_exc_val), .fault_wait(fault_wait)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic s, input logic f, input logic rd,
    input logic [63:0] rpc, input logic [31:0] ins, input logic xen,
    input logic [3:0] xc, input logic [63:0] xv,
    input logic [63:0] ea, input logic ev, input logic [63:0] ep,
    input logic [63:0] e4, input logic [31:0] ei, input logic ex,
    input logic [3:0] ec, input logic [63:0] evl, input logic efw);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.redir = rd; v.rpc = rpc;
    v.instr = ins; v.xen = xen; v.xcode = xc; v.xval = xv;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_p4 = e4;
    v.e_instr = ei; v.e_xen = ex; v.e_code = ec; v.e_val = evl; v.e_fw = efw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: apply inputs away from the edge, wait for the edge, settle.
  task automatic drive(input logic r, input logic s, input logic f, input logic rd,
                       input logic [63:0] rpc, input logic [31:0] ins, input logic xen,
                       input logic [3:0] xc, input logic [63:0] xv);
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_en = rd; redirect_pc = rpc;
    imem_instr = ins; imem_exc_en = xen; imem_exc_code = xc; imem_exc_val = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".imem_addr"},   imem_addr,          v.e_addr);
    chk({tag, ".id_valid"},    {63'd0, id_valid},  {63'd0, v.e_valid});
    chk({tag, ".id_pc"},       id_pc,              v.e_pc);
    chk({tag, ".id_pc_plus4"}, id_pc_plus4,        v.e_p4);
    chk({tag, ".id_instr"},    {32'd0, id_instr},  {32'd0, v.e_instr});
    chk({tag, ".id_exc_en"},   {63'd0, id_exc_en}, {63'd0, v.e_xen});
    chk({tag, ".id_exc_code"}, {60'd0, id_exc_code}, {60'd0, v.e_code});
    chk({tag, ".id_exc_val"},  id_exc_val,         v.e_val);
    chk({tag, ".fault_wait"},  {63'd0, fault_wait}, {63'd0, v.e_fw});
  endtask

  initial begin
    vec_t rv;
    logic [95:0] e;
    //              rst s f rd rpc                 instr        xen xc  xval    | addr                v  id_pc               p4                  instr        x  c  val      fw
    vt[0]  = mk(1, 0, 0, 0, 64'h0,             32'h0,        0, 0, 64'h0,    64'h0,              0, 64'h0,              64'h4,              NOP,         0, 0, 64'h0,     0);
    vt[1]  = mk(0, 0, 0, 0, 64'h0,             32'h00500093, 0, 0, 64'h0,    64'h4,              1, 64'h0,              64'h4,              32'h00500093, 0, 0, 64'h0,    0);
    vt[2]  = mk(0, 0, 0, 0, 64'h0,             32'h00A00113, 0, 0, 64'h0,    64'h8,              1, 64'h4,              64'h8,              32'h00A00113, 0, 0, 64'h0,    0);
    vt[3]  = mk(0, 1, 0, 0, 64'h0,             32'h11111111, 0, 0, 64'h0,    64'h8,              1, 64'h4,              64'h8,              32'h00A00113, 0, 0, 64'h0,    0);
    vt[4]  = mk(0, 1, 0, 0, 64'h0,             32'h22222222, 1, 3, 64'h9,    64'h8,              1, 64'h4,              64'h8,              32'h00A00113, 0, 0, 64'h0,    0);
    vt[5]  = mk(0, 1, 0, 0, 64'h0,             32'h33333333, 0, 0, 64'h0,    64'h8,              1, 64'h4,              64'h8,              32'h00A00113, 0, 0, 64'h0,    0);
    vt[6]  = mk(0, 0, 0, 0, 64'h0,             32'h00308193, 0, 0, 64'h0,    64'hC,              1, 64'h8,              64'hC,              32'h00308193, 0, 0, 64'h0,    0);
    vt[7]  = mk(0, 0, 0, 0, 64'h0,             32'h00418213, 0, 0, 64'h0,    64'h10,             1, 64'hC,              64'h10,             32'h00418213, 0, 0, 64'h0,    0);
    vt[8]  = mk(0, 1, 1, 1, 64'h40,            32'h44444444, 0, 0, 64'h0,    64'h40,             0, 64'hC,              64'h10,             NOP,         0, 0, 64'h0,     0);
    vt[9]  = mk(0, 0, 0, 0, 64'h0,             32'h00000517, 0, 0, 64'h0,    64'h44,             1, 64'h40,             64'h44,             32'h00000517, 0, 0, 64'h0,    0);
    vt[10] = mk(0, 0, 1, 0, 64'h0,             32'h55555555, 0, 0, 64'h0,    64'h44,             0, 64'h40,             64'h44,             NOP,         0, 0, 64'h0,     0);
    vt[11] = mk(0, 0, 0, 1, 64'h2000,          32'h66666666, 0, 0, 64'h0,    64'h2000,           0, 64'h40,             64'h44,             NOP,         0, 0, 64'h0,     0);
    vt[12] = mk(0, 0, 0, 0, 64'h0,             32'h77777777, 1, 1, 64'h2000, 64'h2000,           1, 64'h2000,           64'h2004,           NOP,         1, 1, 64'h2000,  1);
    vt[13] = mk(0, 1, 0, 0, 64'h0,             32'h77777777, 1, 1, 64'h2000, 64'h2000,           1, 64'h2000,           64'h2004,           NOP,         1, 1, 64'h2000,  1);
    vt[14] = mk(0, 0, 0, 0, 64'h0,             32'h77777777, 1, 2, 64'h3000, 64'h2000,           0, 64'h2000,           64'h2004,           NOP,         0, 1, 64'h2000,  1);
    vt[15] = mk(0, 0, 0, 0, 64'h0,             32'h88888888, 0, 0, 64'h0,    64'h2000,           0, 64'h2000,           64'h2004,           NOP,         0, 1, 64'h2000,  1);
    vt[16] = mk(0, 0, 0, 1, 64'h100,           32'h88888888, 0, 0, 64'h0,    64'h100,            0, 64'h2000,           64'h2004,           NOP,         0, 1, 64'h2000,  0);
    vt[17] = mk(0, 0, 0, 0, 64'h0,             32'h00100073, 0, 0, 64'h0,    64'h104,            1, 64'h100,            64'h104,            32'h00100073, 0, 0, 64'h0,    0);
    vt[18] = mk(0, 0, 0, 1, 64'h102,           32'h99999999, 0, 0, 64'h0,    64'h102,            0, 64'h100,            64'h104,            NOP,         0, 0, 64'h0,     0);
    vt[19] = mk(0, 0, 0, 0, 64'h0,             32'h99999999, 1, 5, 64'hDEAD, 64'h102,            1, 64'h102,            64'h106,            NOP,         1, 0, 64'h102,   1);
    vt[20] = mk(1, 1, 0, 1, 64'h500,           32'h99999999, 1, 5, 64'hDEAD, 64'h0,              0, 64'h0,              64'h4,              NOP,         0, 0, 64'h0,     0);
    vt[21] = mk(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 0, 0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,     64'h4,              NOP,         0, 0, 64'h0,     0);
    vt[22] = mk(0, 0, 0, 0, 64'h0,             32'h12345678, 0, 0, 64'h0,    64'h0,              1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,          32'h12345678, 0, 0, 64'h0,    0);
    vt[23] = mk(0, 0, 0, 0, 64'h0,             32'h0AAA0AAA, 0, 0, 64'h0,    64'h4,              1, 64'h0,              64'h4,              32'h0AAA0AAA, 0, 0, 64'h0,    0);

    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0;
    redirect_pc = 64'd0; imem_instr = 32'd0; imem_exc_en = 1'b0;
    imem_exc_code = 4'd0; imem_exc_val = 64'd0;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].rst, vt[i].stall, vt[i].flush, vt[i].redir, vt[i].rpc,
            vt[i].instr, vt[i].xen, vt[i].xcode, vt[i].xval);
      check_all($sformatf("vec%0d", i), vt[i]);
    end

    // Reset while in FAULT_WAIT: fault at PC=4, then rst with stall+redirect.
    drive(0, 0, 0, 0, 64'h0, 32'hBBBBBBBB, 1, 4'd7, 64'h77);
    chk("seq_fault.fault_wait", {63'd0, fault_wait}, 64'd1);
    chk("seq_fault.id_exc_code", {60'd0, id_exc_code}, 64'd7);
    chk("seq_fault.id_pc", id_pc, 64'h4);
    drive(1, 1, 0, 1, 64'h800, 32'hBBBBBBBB, 1, 4'd7, 64'h77);
    rv = mk(0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 64'h0,
            64'h0, 0, 64'h0, 64'h4, NOP, 0, 0, 64'h0, 0);
    check_all("seq_rst_fw", rv);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; imem_exc_en = 1'b0;
    chk("seq_rel.imem_addr", imem_addr, 64'h0);

    // Back-to-back fetch: one slot per edge, one edge of latency.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({64'(i * 4), 32'h0100_0000 + 32'(i)});
      imem_instr = 32'h0100_0000 + 32'(i);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("thru%0d.id_pc", i), id_pc, e[95:32]);
      chk($sformatf("thru%0d.id_instr", i), {32'd0, id_instr}, {32'd0, e[31:0]});
      chk($sformatf("thru%0d.id_valid", i), {63'd0, id_valid}, 64'd1);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction word emitted for bubbles and faulted fetches.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hold PC and IF/ID register contents.
REQ-006 flush  input  1  invalidate IF/ID register at next edge.
REQ-007 redirect_en  input  1  load redirect_pc into PC (branch, jump, trap vector, mret).
REQ-008 redirect_pc  input  64  redirect target.
REQ-009 imem_addr  output  64  fetch address to instruction memory, combinational copy of PC register.
REQ-010 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-011 imem_exc_en  input  1  instruction memory access fault for imem_addr.
REQ-012 imem_exc_code  input  4  memory fault cause.
REQ-013 imem_exc_val  input  64  memory fault tval.
REQ-014 id_valid  output  1  IF/ID register holds a live slot.
REQ-015 id_pc  output  64  PC of the slot.
REQ-016 id_pc_plus4  output  64  id_pc + 4, modulo 2^64.
REQ-017 id_instr  output  32  instruction of the slot.
REQ-018 id_exc_en, id_exc_code[3:0], id_exc_val[63:0]  outputs  fetch exception attached to the slot.
REQ-019 fault_wait  output  1  high while in FAULT_WAIT state.

Function
REQ-020 State machine: two states, RUN and FAULT_WAIT. fault_wait = (state == FAULT_WAIT).
REQ-021 Per-edge priority: rst > redirect_en > flush > stall > normal fetch.
REQ-022 Fetch fault is detected combinationally on the current PC. Misaligned takes priority: when pc[1:0] != 0, cause = 4'd0 and tval = pc. Otherwise, when imem_exc_en = 1, cause = imem_exc_code and tval = imem_exc_val.
REQ-023 RUN, normal fetch, no fault: IF/ID loads {valid=1, pc, pc+4, imem_instr, exc=0}; PC <= PC + 4, wrapping modulo 2^64.
REQ-024 RUN, normal fetch, fault: IF/ID loads {valid=1, pc, pc+4, NOP_INSTR, exc_en=1, cause, tval}; PC holds; state <= FAULT_WAIT.
REQ-025 FAULT_WAIT without redirect: PC holds; imem inputs are ignored. Each non-stalled cycle loads id_valid <= 0. Stalled cycles leave the IF/ID register unchanged, so the fault slot persists until downstream consumes it.
REQ-026 redirect_en = 1, in any state and regardless of stall or flush: PC <= redirect_pc; id_valid <= 0; id_exc_en <= 0; state <= RUN.
REQ-027 Misaligned redirect_pc is accepted without check; the fault is raised on the following fetch per REQ-022 and REQ-024.
REQ-028 flush = 1 without redirect: id_valid <= 0; id_exc_en <= 0; PC holds; state unchanged.
REQ-029 stall = 1 without redirect or flush: PC, state and all id_* outputs hold.
REQ-030 Invalid slots always carry id_instr = NOP_INSTR and id_exc_en = 0.
REQ-031 Fetch latency: the instruction at PC appears on id_* one edge after PC is presented. Sustained throughput is one slot per cycle when not stalled.
REQ-032 Only one fetch exception may be outstanding. Exception slots are never emitted on consecutive non-stalled cycles without an intervening redirect.

Reset
REQ-033 On rst at a clock edge: PC <= RESET_PC; state <= RUN; id_valid <= 0; id_pc <= 0; id_pc_plus4 <= 4; id_instr <= NOP_INSTR; id_exc_en <= 0; id_exc_code <= 0; id_exc_val <= 0.
REQ-034 rst asserted mid-operation, including in FAULT_WAIT or together with redirect_en or stall, overrides everything and yields exactly the REQ-033 values.
REQ-035 imem_addr equals RESET_PC in the cycle after reset is released.

Verification
REQ-036 Reset release, imem returns 0x00500093 at addr 0 and 0x00A00113 at addr 4 -> id_pc=0, id_instr=0x00500093, then id_pc=4, id_instr=0x00A00113, id_pc_plus4=8, id_valid=1 both cycles.
REQ-037 Stall asserted 3 cycles at PC=8 -> imem_addr stays 8 and id_* stays frozen; release -> PC=8 slot then PC=12.
REQ-038 Redirect to 0x40 with stall=1 and flush=1 -> next edge id_valid=0 and imem_addr=0x40; following edge slot pc=0x40.
REQ-039 imem_exc_en=1, code=1, val=0x2000 at PC=0x2000 -> slot {valid=1, instr=0x13, exc_en=1, code=1, val=0x2000}, fault_wait=1; next cycles id_valid=0 and PC held at 0x2000 until redirect to 0x100, after which fault_wait=0 and fetch resumes at 0x100.
REQ-040 Redirect to 0x102 -> slot {exc_en=1, code=0, val=0x102}; imem_exc_en asserted simultaneously is ignored, misaligned wins.
REQ-041 PC=0xFFFF_FFFF_FFFF_FFFC with valid fetch -> id_pc_plus4=0 and next imem_addr=0. Also: rst during FAULT_WAIT -> all REQ-033 values and state RUN.
